// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_meter_pkg;

    // Default period counter width; the largest reportable period is 2^WIDTH-1.
    localparam int DEF_WIDTH  = 14;
    // Default largest period change, in clk_in cycles, still treated as stable.
    localparam int DEF_TOL    = 4;
    // Default number of consecutive stable comparisons before locked rises.
    localparam int DEF_LOCK_N = 4;

    // SEARCH : no reference edge yet
    // MEASURE: one edge seen, counting towards the first period
    // TRACK  : at least one period reported
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TRACK   = 2'd2
    } meter_state_e;

endpackage

// File: rtl/sig_sync.sv
// Synchronises the asynchronous sig_in into clk_in and flags its rising edges.
// Latency: rise is high in the third cycle after the first clk_in edge that samples sig_in high.
// Backpressure: none; sig_in is free-running and cannot be stalled.
//
// Ports:
//   clk_in  system clock
//   rst_n   asynchronous active-low reset
//   sig_in  asynchronous measured signal
//   rise    one-cycle pulse per detected rising edge of sig_in
module sig_sync (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;
    logic rise_q,  rise_d;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        // Edge = synchronised level high while its history is still low.
        // Registering the flag keeps the path into the meter FSM flop-to-flop.
        rise_d  = sync2_q & ~hist_q;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of sig_in in clk_in cycles and reports stability (locked) and loss (lost).
// Latency: period_valid is high 3 cycles after the first clk_in edge that samples a sig_in rise.
// Backpressure: none; outputs are pulses/levels with no handshake and cannot be stalled.
//
// Ports:
//   clk_in        system clock (only clock)
//   rst_n         asynchronous active-low reset
//   sig_in        measured slow signal, asynchronous to clk_in
//   period        last measured period in clk_in cycles
//   period_valid  one-cycle pulse when period updates
//   locked        high while consecutive periods stay within TOL
//   lost          one-cycle pulse when no edge arrives for 2^WIDTH-1 cycles
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TOL    = DEF_TOL,
    parameter int LOCK_N = DEF_LOCK_N
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);

    // Stable counter only needs to reach LOCK_N (it saturates there).
    localparam int               SW       = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [SW-1:0]    LOCK_LIM = SW'(LOCK_N);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    // TOL is expected to fit in WIDTH bits; any larger tolerance is meaningless anyway.
    localparam logic [WIDTH-1:0] TOL_W    = WIDTH'(TOL);

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             locked_q, locked_d;

    logic             rise;
    logic             timeout;
    logic [WIDTH-1:0] new_period;
    logic [WIDTH-1:0] abs_diff;
    logic             stable;
    logic [SW-1:0]    stab_inc;

    sig_sync u_sig_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // Timeout has priority over an edge arriving in the same cycle.
    assign timeout    = (state_q != ST_SEARCH) && (cnt_q == CNT_MAX);
    // cnt_q never reaches CNT_MAX here without timing out, so +1 cannot wrap when used.
    assign new_period = cnt_q + 1'b1;
    // Subtract the smaller from the larger so the difference never wraps.
    assign abs_diff   = (new_period >= period_q) ? (new_period - period_q)
                                                 : (period_q - new_period);
    assign stable     = (abs_diff <= TOL_W);
    assign stab_inc   = (stab_q < LOCK_LIM) ? (stab_q + 1'b1) : stab_q;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE, ST_TRACK: begin
                if (timeout) begin
                    state_d = ST_SEARCH;
                end else if (rise) begin
                    state_d = ST_TRACK;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // ---------------------------------------------------------------- datapath / outputs
    always_comb begin
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        stab_d         = stab_q;
        locked_d       = locked_q;
        case (state_q)
            ST_MEASURE: begin
                if (timeout) begin
                    cnt_d    = '0;
                    stab_d   = '0;
                    locked_d = 1'b0;
                end else if (rise) begin
                    // First period is reported but never compared: no previous one exists.
                    cnt_d          = '0;
                    period_d       = new_period;
                    period_valid_d = 1'b1;
                    stab_d         = '0;
                    locked_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TRACK: begin
                if (timeout) begin
                    cnt_d    = '0;
                    stab_d   = '0;
                    locked_d = 1'b0;
                end else if (rise) begin
                    cnt_d          = '0;
                    period_d       = new_period;
                    period_valid_d = 1'b1;
                    if (stable) begin
                        stab_d   = stab_inc;
                        locked_d = (stab_inc == LOCK_LIM);
                    end else begin
                        stab_d   = '0;
                        locked_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // SEARCH: no reference edge, so nothing to count.
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stab_q         <= '0;
            locked_q       <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stab_q         <= stab_d;
            locked_q       <= locked_d;
        end
    end

    // lost is decoded straight from registered state so it shows in the cycle the counter
    // tops out; locked is masked in that same cycle rather than one cycle later.
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign lost         = timeout;
    assign locked       = locked_q & ~timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

    localparam int WIDTH  = 14;
    localparam int TOL    = 4;
    localparam int LOCK_N = 4;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             lost;

    clk_period_meter #(
        .WIDTH  (WIDTH),
        .TOL    (TOL),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int per;
        bit lck;
        int at;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model of the meter, driven by the bench's own edge timestamps.
    int   m_state = 0;
    int   m_last  = 0;
    int   m_prev  = 0;
    int   m_stab  = 0;

    int   lost_cnt       = 0;
    int   lost_cyc       = -1;
    int   last_valid_cyc = -1;
    logic lost_locked    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A rising edge of sig_in driven at the negedge following posedge number c.
    task automatic model_edge(input int c);
        int  t;
        int  d;
        bit  lck;
        if (m_state == 0) begin
            m_state = 1;
            m_last  = c;
        end else begin
            t      = c - m_last;
            m_last = c;
            lck    = 1'b0;
            if (m_state == 1) begin
                m_state = 2;
                m_stab  = 0;
            end else begin
                d = (t > m_prev) ? (t - m_prev) : (m_prev - t);
                if (d <= TOL) begin
                    if (m_stab < LOCK_N) m_stab++;
                end else begin
                    m_stab = 0;
                end
                lck = (m_stab == LOCK_N);
            end
            m_prev = t;
            // Sampled at posedge c+1, reported after posedge c+4 (3 cycles later).
            sb.push_back('{t, lck, c + 4});
        end
    endtask

    // One sig_in period of p cycles, starting with a rising edge. Call at a negedge.
    task automatic pulse_period(input int p);
        sig_in = 1'b1;
        model_edge(cyc);
        repeat (p / 2) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (p - p / 2) @(negedge clk_in);
    endtask

    // Output monitor / scoreboard consumer.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            check("valid_lost_exclusive", 32'(period_valid & lost), 32'd0);
            if (period_valid === 1'b1) begin
                last_valid_cyc = cyc;
                check("valid_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("period", 32'(period), 32'(e.per));
                    check("locked_at_valid", 32'(locked), 32'(e.lck));
                    check("valid_latency", 32'(cyc), 32'(e.at));
                end
            end
            if (lost === 1'b1) begin
                lost_cnt++;
                lost_cyc    = cyc;
                lost_locked = locked;
            end
        end
    end

    initial begin
        int waited;

        rst_n  = 1'b0;
        sig_in = 1'b0;
        #1;
        check("rst_period", 32'(period), 32'd0);
        check("rst_valid", 32'(period_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);

        // Fastest legal input: 2 high / 2 low.
        for (int i = 0; i < 8; i++) pulse_period(4);
        repeat (8) @(negedge clk_in);
        check("no_lost_fast", 32'(lost_cnt), 32'd0);
        check("locked_fast", 32'(locked), 32'd1);

        // Lock at 202, jump by 8 (> TOL) to 210 and re-lock, then wobble by <= TOL.
        for (int i = 0; i < 7; i++) pulse_period(202);
        for (int i = 0; i < 5; i++) pulse_period(210);
        for (int i = 0; i < 12; i++) pulse_period(200 + 2 * (i % 3));
        check("locked_wobble", 32'(locked), 32'd1);

        // Long period, then sig_in stays low until the meter times out.
        pulse_period(12002);
        pulse_period(12002);
        waited = 0;
        while (lost_cnt == 0 && waited < 20000) begin
            @(posedge clk_in);
            waited++;
        end
        check("lost_seen", 32'(lost_cnt), 32'd1);
        check("lost_gap", 32'(lost_cyc - last_valid_cyc), 32'd16383);
        check("lost_locked", 32'(lost_locked), 32'd0);
        check("sb_empty_at_lost", 32'(sb.size()), 32'd0);
        @(negedge clk_in);
        check("period_hold", 32'(period), 32'd12002);
        check("locked_after_lost", 32'(locked), 32'd0);
        m_state = 0;
        m_stab  = 0;

        // Restart: first edge only re-arms, then lock again at 100.
        for (int i = 0; i < 7; i++) pulse_period(100);
        sig_in = 1'b1;
        model_edge(cyc);
        repeat (30) @(negedge clk_in);
        sig_in = 1'b0;
        repeat (20) @(negedge clk_in);
        check("locked_before_rst", 32'(locked), 32'd1);
        check("period_before_rst", 32'(period), 32'd100);

        // Reset in the middle of a period.
        rst_n = 1'b0;
        #1;
        check("mid_rst_period", 32'(period), 32'd0);
        check("mid_rst_valid", 32'(period_valid), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_lost", 32'(lost), 32'd0);
        check("sb_empty_at_rst", 32'(sb.size()), 32'd0);
        sb.delete();
        m_state = 0;
        m_stab  = 0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 3; i++) pulse_period(150);
        repeat (10) @(posedge clk_in);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("lost_total", 32'(lost_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
